// File: rtl/pq_cell_sr.sv
// rtl/pq_cell_sr.sv - one storage cell of the shift-register array priority queue
// Holds (vld, key, id) and picks its next entry from self, broadcast operand or a neighbour.
module pq_cell_sr #(
  parameter int PW        = 8,
  parameter int TW        = 4,
  parameter bit MAX_FIRST = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [2:0]    op_i,
  input  logic [PW-1:0] key_i,
  input  logic [TW-1:0] id_i,
  input  logic          left_vld_i,
  input  logic [PW-1:0] left_key_i,
  input  logic [TW-1:0] left_id_i,
  input  logic          left_disp_i,
  input  logic          left_match_i,
  input  logic          left_place_i,
  input  logic          right_vld_i,
  input  logic [PW-1:0] right_key_i,
  input  logic [TW-1:0] right_id_i,
  output logic          vld_o,
  output logic [PW-1:0] key_o,
  output logic [TW-1:0] id_o,
  output logic          disp_o,
  output logic          match_o,
  output logic          place_o
);

  localparam logic [2:0] OP_PUSH    = 3'b001;
  localparam logic [2:0] OP_POP     = 3'b010;
  localparam logic [2:0] OP_DROP    = 3'b011;
  localparam logic [2:0] OP_PUSHPOP = 3'b100;

  logic          vld_q, vld_d;
  logic [PW-1:0] key_q, key_d;
  logic [TW-1:0] id_q, id_d;
  logic          new_ahead, right_ahead, id_hit;
  logic          disp, match, place;

  // Strict comparison: an equal new key never overtakes, which keeps equal keys FIFO.
  function automatic logic ranks_ahead(input logic [PW-1:0] a, input logic [PW-1:0] b);
    if (MAX_FIRST) return a > b;
    else           return a < b;
  endfunction

  always_comb begin
    new_ahead   = ranks_ahead(key_i, key_q);
    right_ahead = right_vld_i & ~ranks_ahead(key_i, right_key_i);
    id_hit      = vld_q & (id_q == id_i);
    vld_d       = vld_q;
    key_d       = key_q;
    id_d        = id_q;
    disp        = 1'b0;
    match       = 1'b0;
    place       = 1'b0;
    case (op_i)
      OP_PUSH: begin
        disp = vld_q & (left_disp_i | new_ahead);
        if (left_disp_i) begin
          vld_d = left_vld_i;
          key_d = left_key_i;
          id_d  = left_id_i;
        end else if (vld_q ? new_ahead : left_vld_i) begin
          vld_d = 1'b1;
          key_d = key_i;
          id_d  = id_i;
        end
      end
      OP_POP: begin
        vld_d = right_vld_i;
        key_d = right_key_i;
        id_d  = right_id_i;
      end
      OP_DROP: begin
        match = left_match_i | id_hit;
        if (match) begin
          vld_d = right_vld_i;
          key_d = right_key_i;
          id_d  = right_id_i;
        end
      end
      OP_PUSHPOP: begin
        // Cells ahead of the insertion point shift up to fill the popped head.
        place = left_place_i;
        if (!left_place_i) begin
          if (right_ahead) begin
            vld_d = right_vld_i;
            key_d = right_key_i;
            id_d  = right_id_i;
          end else begin
            vld_d = 1'b1;
            key_d = key_i;
            id_d  = id_i;
            place = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= 1'b0;
      key_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      key_q <= key_d;
      id_q  <= id_d;
    end
  end

  assign vld_o   = vld_q;
  assign key_o   = key_q;
  assign id_o    = id_q;
  // Chain outputs are held low while in reset so the neighbours see a quiet chain.
  assign disp_o  = disp & rst_ni;
  assign match_o = match & rst_ni;
  assign place_o = place & rst_ni;

endmodule
